// File: rtl/sv_uart_word_rx.sv
// rtl/sv_uart_word_rx.sv - 8N1 UART receiver that packs bytes into DATA_WIDTH-bit stream words
//
// Receives 8N1 bytes on irx and packs them into DATA_WIDTH-bit words, first
// byte in the most significant position. Each word is presented on a
// tdata/tvalid/tready output stream.
//
// Ports:
//   iclk          - clock, rising edge
//   irst          - asynchronous active-high reset
//   irx           - serial line, idle high, asynchronous to iclk
//   idivider      - iclk cycles per bit period, latched at each start bit
//   m_axis_tdata  - assembled word
//   m_axis_tvalid - word valid, held until accepted
//   m_axis_tready - downstream accept
//   oframe_err    - one-cycle pulse when a stop bit is sampled low
//   ooverrun      - one-cycle pulse when a completed word is dropped
module sv_uart_word_rx #(
    parameter int DATA_WIDTH   = 24,
    parameter int RX_PIPE      = 5,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  irx,
    input  logic [15:0]           idivider,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  oframe_err,
    output logic                  ooverrun
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BC_W  = $clog2(BYTES + 1);
    // Sized so that TIMEOUT_BITS * 65535 idle cycles never wraps.
    localparam int TO_W  = $clog2(TIMEOUT_BITS * 65535 + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [RX_PIPE-1:0]    r_sync;
    logic                  r_rxs_prev;
    logic [15:0]           r_div;
    logic [15:0]           r_cnt;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic [DATA_WIDTH-1:0] r_word;
    logic [BC_W-1:0]       r_byte_cnt;
    logic [TO_W-1:0]       r_to_cnt;

    logic                  w_rxs;
    logic                  w_fall;
    logic                  w_expire;
    logic [15:0]           w_div_in;
    logic                  w_start;
    logic                  w_shift_en;
    logic                  w_commit;
    logic                  w_ferr;
    logic [DATA_WIDTH-1:0] w_word_next;
    logic                  w_word_done;
    logic                  w_can_load;
    logic                  w_load;
    logic                  w_overrun;
    logic [TO_W-1:0]       w_to_limit;
    logic                  w_to_hit;

    assign w_rxs    = r_sync[RX_PIPE-1];
    assign w_fall   = r_rxs_prev & ~w_rxs;
    // A counter loaded with N expires N cycles after the load, so samples
    // taken on successive reloads with div are exactly one bit period apart.
    assign w_expire = (r_cnt <= 16'd1);
    // Dividers below 2 cannot place a sample inside the bit; clamp to 2.
    assign w_div_in = (idivider < 16'd2) ? 16'd2 : idivider;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_commit     = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_next = S_START;
                    w_start      = 1'b1;
                end
            end
            S_START: begin
                // A high line at mid start bit was a glitch: drop silently.
                if (w_expire) begin
                    w_state_next = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_expire) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_expire) begin
                    w_state_next = S_IDLE;
                    w_commit     = w_rxs;
                    w_ferr       = ~w_rxs;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Line synchronizer and bit timing
    // ------------------------------------------------------------------
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_sync     <= '1;
            r_rxs_prev <= 1'b1;
            r_div      <= 16'd0;
            r_cnt      <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
        end else begin
            r_sync     <= {r_sync[RX_PIPE-2:0], irx};
            r_rxs_prev <= w_rxs;
            if (w_start) begin
                r_div     <= w_div_in;
                r_cnt     <= w_div_in >> 1;
                r_bit_idx <= 3'd0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= w_expire ? r_div : r_cnt - 16'd1;
            end
            if (w_shift_en) begin
                r_shift   <= {w_rxs, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word assembly and partial-word timeout
    // ------------------------------------------------------------------
    assign w_word_next = {r_word[DATA_WIDTH-9:0], r_shift};
    assign w_word_done = w_commit && (r_byte_cnt == BC_W'(BYTES - 1));
    assign w_can_load  = !m_axis_tvalid || m_axis_tready;
    assign w_load      = w_word_done && w_can_load;
    assign w_overrun   = w_word_done && !w_can_load;
    assign w_to_limit  = TO_W'(r_div) * TO_W'(TIMEOUT_BITS);
    // A new start bit restarts the idle count rather than expiring it.
    assign w_to_hit    = (r_state == S_IDLE) && (r_byte_cnt != '0) && !w_fall &&
                         ((r_to_cnt + TO_W'(1)) >= w_to_limit);

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            if (w_ferr || w_to_hit) begin
                r_word     <= '0;
                r_byte_cnt <= '0;
            end else if (w_commit) begin
                r_word     <= w_word_next;
                r_byte_cnt <= w_word_done ? '0 : r_byte_cnt + BC_W'(1);
            end
            if (w_fall || (r_state != S_IDLE) || (r_byte_cnt == '0) || w_to_hit) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stream and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            oframe_err    <= 1'b0;
            ooverrun      <= 1'b0;
        end else begin
            // Loading takes priority so a word completing on a handshake
            // cycle keeps tvalid high without a gap.
            if (w_load) begin
                m_axis_tdata  <= w_word_next;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            oframe_err <= w_ferr;
            ooverrun   <= w_overrun;
        end
    end

endmodule

// File: tb/tb_sv_uart_word_rx.sv
// tb/tb_sv_uart_word_rx.sv - self-checking bench for sv_uart_word_rx
module tb_sv_uart_word_rx;

    localparam int DW = 24;

    logic          iclk = 1'b0;
    logic          irst = 1'b1;
    logic          irx = 1'b1;
    logic [15:0]   idivider = 16'd16;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          oframe_err;
    logic          ooverrun;

    sv_uart_word_rx #(.DATA_WIDTH(DW), .RX_PIPE(5), .TIMEOUT_BITS(20)) dut (
        .iclk          (iclk),
        .irst          (irst),
        .irx           (irx),
        .idivider      (idivider),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .oframe_err    (oframe_err),
        .ooverrun      (ooverrun)
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_errors = 0;

    // Observed stream, written only by the monitor.
    logic [DW-1:0] got_q[$];
    int got_ferr = 0;
    int got_ovr = 0;
    int valid_cycles = 0;

    // Snapshot points owned by the main sequence.
    int base_word = 0;
    int base_ferr = 0;
    int base_ovr = 0;

    // Reference model: bytes accumulate into a partial word of DW/8 bytes.
    logic [7:0]    m_part[$];
    logic [DW-1:0] exp_q[$];
    int exp_ferr = 0;
    int exp_ovr = 0;
    bit m_hold_mode = 1'b0;
    bit m_held = 1'b0;
    int bit_cyc = 16;

    always @(negedge iclk) begin
        if (!irst) begin
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
            if (m_axis_tvalid) valid_cycles++;
            if (oframe_err) got_ferr++;
            if (ooverrun) got_ovr++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_byte(input logic [7:0] b);
        logic [DW-1:0] w;
        m_part.push_back(b);
        if (m_part.size() == DW / 8) begin
            w = '0;
            foreach (m_part[i]) w = (w << 8) | DW'(m_part[i]);
            m_part.delete();
            if (m_hold_mode && m_held) begin
                exp_ovr++;
            end else begin
                exp_q.push_back(w);
                if (m_hold_mode) m_held = 1'b1;
            end
        end
    endfunction

    function automatic void m_ferr();
        exp_ferr++;
        m_part.delete();
    endfunction

    task automatic drive_bit(input logic v, input int cyc);
        irx = v;
        repeat (cyc) @(posedge iclk);
        #1;
    endtask

    task automatic idle(input int cyc);
        drive_bit(1'b1, cyc);
    endtask

    task automatic set_div(input logic [15:0] d);
        idivider = d;
        bit_cyc  = (d < 16'd2) ? 2 : int'(d);
    endtask

    // One 8N1 frame; optionally scrambles idivider while data bits are on
    // the line and restores it before the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit scramble);
        logic [15:0] saved;
        saved = idivider;
        drive_bit(1'b0, bit_cyc);
        if (scramble) idivider = 16'($urandom);
        for (int i = 0; i < 8; i++) drive_bit(b[i], bit_cyc);
        idivider = saved;
        drive_bit(stop, bit_cyc);
        if (stop) m_byte(b);
        else m_ferr();
    endtask

    task automatic compare(input string tag);
        int n_got;
        n_got = got_q.size() - base_word;
        check({tag, " word count"}, 64'(n_got), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_got; i++)
            check({tag, " word"}, 64'(got_q[base_word + i]), 64'(exp_q[i]));
        check({tag, " frame_err pulses"}, 64'(got_ferr - base_ferr), 64'(exp_ferr));
        check({tag, " overrun pulses"}, 64'(got_ovr - base_ovr), 64'(exp_ovr));
        base_word = got_q.size();
        base_ferr = got_ferr;
        base_ovr  = got_ovr;
        exp_q.delete();
        exp_ferr = 0;
        exp_ovr  = 0;
    endtask

    initial begin
        int vbase;
        int nb;
        logic [7:0] rb;
        logic rs;
        logic [7:0] b66;

        // Reset state
        repeat (3) @(posedge iclk);
        #1;
        check("reset tdata", 64'(m_axis_tdata), 64'h0);
        check("reset tvalid", 64'(m_axis_tvalid), 64'h0);
        check("reset frame_err", 64'(oframe_err), 64'h0);
        check("reset overrun", 64'(ooverrun), 64'h0);
        irst = 1'b0;
        idle(20);

        // Three back-to-back bytes form one word, valid for one cycle
        vbase = valid_cycles;
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(40);
        check("basic word literal", 64'(got_q[got_q.size() - 1]), 64'hA53C7E);
        compare("basic");
        check("basic tvalid cycles", 64'(valid_cycles - vbase), 64'd1);

        // Short low glitch is ignored
        drive_bit(1'b0, 4);
        idle(40);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        idle(40);
        compare("glitch");

        // Framing error discards the byte
        send_frame(8'hA5, 1'b0, 1'b0);
        idle(2 * bit_cyc);
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        idle(40);
        compare("frame_err");

        // Backpressure: second word overruns, held word unchanged
        m_axis_tready = 1'b0;
        m_hold_mode = 1'b1;
        m_held = 1'b0;
        for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1, 1'b0);
        idle(40);
        check("hold tvalid", 64'(m_axis_tvalid), 64'h1);
        check("hold tdata", 64'(m_axis_tdata), 64'h010203);
        m_axis_tready = 1'b1;
        m_hold_mode = 1'b0;
        idle(5);
        check("after accept tvalid", 64'(m_axis_tvalid), 64'h0);
        compare("overrun");

        // Partial word times out after 20 idle bit periods
        send_frame(8'hAA, 1'b1, 1'b0);
        send_frame(8'hBB, 1'b1, 1'b0);
        idle(20 * 16 + 5);
        m_part.delete();
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        idle(40);
        compare("timeout");

        // Reset mid-frame with a held word pending
        m_axis_tready = 1'b0;
        m_hold_mode = 1'b1;
        m_held = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0);
        send_frame(8'h88, 1'b1, 1'b0);
        send_frame(8'h99, 1'b1, 1'b0);
        idle(40);
        check("pre-reset held tdata", 64'(m_axis_tdata), 64'h778899);
        send_frame(8'h55, 1'b1, 1'b0);
        b66 = 8'h66;
        drive_bit(1'b0, bit_cyc);
        for (int i = 0; i < 4; i++) drive_bit(b66[i], bit_cyc);
        drive_bit(b66[4], bit_cyc / 2);
        irst = 1'b1;
        @(negedge iclk);
        check("in-reset tdata", 64'(m_axis_tdata), 64'h0);
        check("in-reset tvalid", 64'(m_axis_tvalid), 64'h0);
        check("in-reset frame_err", 64'(oframe_err), 64'h0);
        check("in-reset overrun", 64'(ooverrun), 64'h0);
        exp_q.delete();
        m_part.delete();
        m_held = 1'b0;
        m_hold_mode = 1'b0;
        irx = 1'b1;
        repeat (4) @(posedge iclk);
        #1;
        irst = 1'b0;
        m_axis_tready = 1'b1;
        idle(20);
        send_frame(8'hC0, 1'b1, 1'b0);
        send_frame(8'hC1, 1'b1, 1'b0);
        send_frame(8'hC2, 1'b1, 1'b0);
        idle(40);
        compare("reset");

        // Divider below 2 is clamped to 2
        for (int d = 0; d < 2; d++) begin
            set_div(16'(d));
            idle(20);
            for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, 1'b0);
            idle(40);
            compare("min divider");
        end

        // Randomized bytes, stop errors, gaps and dividers; alternating
        // rounds change idivider mid-frame.
        for (int r = 0; r < 4; r++) begin
            set_div(16'($urandom_range(6, 24)));
            idle(30);
            nb = 3 * $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                rb = 8'($urandom);
                rs = ($urandom_range(0, 7) != 0);
                send_frame(rb, rs, r[0]);
                if (!rs) idle(2 * bit_cyc);
                else idle($urandom_range(0, 3 * bit_cyc));
            end
            idle(22 * bit_cyc);
            m_part.delete();
            compare("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sv_uart_word_rx.md
SV_UART_WORD_RX -- requirements
Module: sv_uart_word_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning output word width; must be a multiple of 8 and at least 16.
REQ-002 SHALL have parameter RX_PIPE, default 5, meaning synchronizer/debounce flops on irx; must be at least 2.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20, meaning idle bit-periods after which a partial word is discarded.
REQ-004 SHALL have port iclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port irst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port irx, input, 1 bit: serial line, idle high, asynchronous to iclk.
REQ-007 SHALL have port idivider, input, 16 bits: iclk cycles per bit period.
REQ-008 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: assembled word.
REQ-009 SHALL have port m_axis_tvalid, output, 1 bit: word valid.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: downstream accept.
REQ-011 SHALL have port oframe_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-012 SHALL have port ooverrun, output, 1 bit: one-cycle pulse when a completed word is dropped.

Function
REQ-013 SHALL pass irx through RX_PIPE flops reset to 1; all decisions use the last stage (rxs), with a falling edge defined as previous rxs=1 and current rxs=0.
REQ-014 SHALL latch idivider at start-bit detection as div; a latched value below 2 is used as 2; idivider changes mid-frame have no effect.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE->START on a falling edge of rxs; the bit counter loads div/2 (floor).
REQ-017 In START, when the counter expires, the block SHALL sample rxs: if 1 (glitch), return to IDLE with no byte and no error; if 0, go to DATA with the counter reloaded to div.
REQ-018 In DATA, the block SHALL sample rxs each time the counter expires, 8 samples LSB first, reloading the counter to div after each, then go to STOP.
REQ-019 In STOP, on counter expiry the block SHALL sample rxs: if 1, commit the byte; if 0, pulse oframe_err, discard the byte and clear the partial word; both cases return to IDLE.
REQ-020 On a byte commit, the block SHALL set word = {word[DATA_WIDTH-9:0], byte} and increment byte_cnt, so the first received byte ends in the MS byte of m_axis_tdata.
REQ-021 When byte_cnt reaches DATA_WIDTH/8, the block SHALL load m_axis_tdata and assert m_axis_tvalid the following cycle; byte_cnt SHALL be cleared to 0 in the same cycle.
REQ-022 m_axis_tvalid SHALL stay high and m_axis_tdata stable until a cycle with m_axis_tvalid && m_axis_tready; tvalid SHALL deassert after that cycle unless a new word loads in the same cycle.
REQ-023 A word completing in the same cycle as a handshake SHALL be loaded, keeping tvalid high with no overrun.
REQ-024 A word completing while tvalid=1 and tready=0 SHALL be dropped with a one-cycle ooverrun pulse; the held word SHALL be unchanged.
REQ-025 While in IDLE with byte_cnt>0, the block SHALL count idle cycles; on reaching TIMEOUT_BITS*div, it SHALL clear byte_cnt and the partial word silently; the count resets on any start detection.
REQ-026 Counters SHALL be wide enough for TIMEOUT_BITS*65535 without wrap.

Reset
REQ-027 On irst=1, the block SHALL asynchronously set: FSM=IDLE, counters=0, byte_cnt=0, synchronizer flops=1, m_axis_tdata=0, m_axis_tvalid=0, oframe_err=0, ooverrun=0.
REQ-028 Reset asserted mid-frame or mid-word SHALL discard all partial data; after release, the block SHALL wait for a new falling edge and not resume the old frame.

Verification (DATA_WIDTH=24, idivider=16, RX_PIPE=5)
REQ-029 Send bytes A5, 3C, 7E back-to-back, 8N1, tready=1 -> exactly one word with tdata=0xA53C7E and tvalid high for 1 cycle; no error pulses.
REQ-030 Drive irx low for 4 cycles, then high -> no byte, no oframe_err, FSM back in IDLE; then send 3 bytes 11, 22, 33 -> tdata=0x112233.
REQ-031 Send A5 with the stop bit low, then 01, 02, 03 -> one oframe_err pulse; next word=0x010203.
REQ-032 Hold tready=0 and send 6 bytes 01..06 -> tdata stays 0x010203, one ooverrun pulse; raise tready -> 0x010203 accepted, then tvalid=0.
REQ-033 Send AA, BB, idle 20*16+5 cycles, then 01, 02, 03 -> single word 0x010203; AA/BB never appear.
REQ-034 Assert irst during bit 4 of the second byte, release, then send C0, C1, C2 -> outputs at reset values during reset; the only word is 0xC0C1C2.
